// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame configuration and data-length helpers.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    // data_bits field encoding
    localparam logic [1:0] DB5 = 2'b00;
    localparam logic [1:0] DB6 = 2'b01;
    localparam logic [1:0] DB7 = 2'b10;
    localparam logic [1:0] DB8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } rx_state_e;

    // Frame format, latched once per character so mid-frame writes cannot corrupt it
    typedef struct packed {
        logic [1:0] data_bits;
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } rx_cfg_t;

    // Index of the last data bit for a given data_bits encoding (N-1)
    function automatic logic [2:0] last_bit_index(input logic [1:0] db);
        logic [2:0] idx;
        idx = 3'd7;
        case (db)
            DB5: idx = 3'd4;
            DB6: idx = 3'd5;
            DB7: idx = 3'd6;
            DB8: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one PCLK-wide tick every baud_div cycles, idle when baud_div is 0.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             enable;

    assign enable = (baud_div != '0);
    assign tick   = enable && (cnt == '0);

    // Down-counter; the divisor is only read on reload so a change lands at the next period
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= baud_div - DIV_W'(1);
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: 16x oversampled start/data/parity/stop decode with a valid/ready holding register.
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             RX,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det,
    output logic             overrun_err,
    output logic             rx_busy
);

    import uart_pkg::*;

    localparam int             PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic            rx_meta;
    logic            rxs;
    logic            armed;
    logic            tick;
    logic            enable;
    logic            start_edge;
    logic            bit_sample;
    rx_state_e       state;
    logic [PH_W-1:0] phase;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            par_acc;
    logic            all_zero;
    logic            par_err_r;
    logic            frame_r;
    logic            done;
    rx_cfg_t         cfg;
    rx_cfg_t         cfg_in;

    assign enable     = (baud_div != '0);
    assign start_edge = armed && !rxs;
    assign bit_sample = tick && (phase == PH_LAST);
    assign rx_busy    = (state != IDLE);

    assign cfg_in.data_bits  = data_bits;
    assign cfg_in.parity_en  = parity_en;
    assign cfg_in.parity_odd = parity_odd;
    assign cfg_in.stop2      = stop2;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // Two-flop synchronizer, preset high to match an idle line
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // Arms start detection only after a high line has been seen in IDLE, so a stuck-low line cannot retrigger
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            armed <= 1'b1;
        end else begin
            armed <= (state == IDLE) && rxs;
        end
    end

    // Frame FSM with mid-bit sampling, shift register and per-frame error accumulation
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            all_zero  <= 1'b0;
            par_err_r <= 1'b0;
            frame_r   <= 1'b0;
            done      <= 1'b0;
            cfg       <= '0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                phase <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_edge) begin
                            state <= START;
                            phase <= '0;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (phase == PH_MID) begin
                                phase <= '0;
                                if (rxs) begin
                                    state <= IDLE;
                                end else begin
                                    state     <= DATA;
                                    cfg       <= cfg_in;
                                    bit_idx   <= '0;
                                    shreg     <= '0;
                                    par_acc   <= 1'b0;
                                    all_zero  <= 1'b1;
                                    par_err_r <= 1'b0;
                                    frame_r   <= 1'b0;
                                end
                            end else begin
                                phase <= phase + PH_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (bit_sample) begin
                            phase          <= '0;
                            shreg[bit_idx] <= rxs;
                            par_acc        <= par_acc ^ rxs;
                            all_zero       <= all_zero & ~rxs;
                            if (bit_idx == last_bit_index(cfg.data_bits)) begin
                                state <= cfg.parity_en ? PARITY : STOP1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else if (tick) begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_sample) begin
                            phase     <= '0;
                            par_err_r <= ((par_acc ^ rxs) != cfg.parity_odd);
                            all_zero  <= all_zero & ~rxs;
                            state     <= STOP1;
                        end else if (tick) begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    STOP1: begin
                        if (bit_sample) begin
                            phase    <= '0;
                            frame_r  <= ~rxs;
                            all_zero <= all_zero & ~rxs;
                            if (cfg.stop2) begin
                                state <= STOP2;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else if (tick) begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    STOP2: begin
                        if (bit_sample) begin
                            phase   <= '0;
                            frame_r <= frame_r | ~rxs;
                            state   <= IDLE;
                            done    <= 1'b1;
                        end else if (tick) begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

    // Holding register: load on completion when free or being consumed, otherwise drop and flag overrun
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shreg;
                    parity_err <= par_err_r;
                    frame_err  <= frame_r;
                    break_det  <= all_zero;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed frames, per-cycle comparison against a frame-level model.
module tb_uart_rx_core;

    localparam int OS      = 16;
    localparam int DIV_W   = 16;
    localparam int BD      = 4;
    localparam int BIT_CYC = BD * OS;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             RX = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'(BD);
    logic [1:0]       data_bits = 2'b11;
    logic             parity_en = 1'b0;
    logic             parity_odd = 1'b0;
    logic             stop2 = 1'b0;
    logic             rx_ready = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             parity_err;
    logic             frame_err;
    logic             break_det;
    logic             overrun_err;
    logic             rx_busy;

    typedef struct {
        int         rise;
        logic [7:0] data;
        bit         pe;
        bit         fe;
        bit         bd;
    } frame_t;

    frame_t expQ[$];
    frame_t held;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     tickBase = 0;
    int     ovSeen = 0;
    bit     mValid = 0;
    bit     prevRdy = 0;
    bit     prevVld = 0;

    uart_rx_core #(
        .OVERSAMPLE(OS),
        .DIV_W     (DIV_W)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .RX         (RX),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Edge index at which rx_valid must appear: ticks fall on tickBase + j*BD, the frame counts
    // ticks from edge p+4 (two sync flops plus start detection), the k-th counted tick samples the
    // last stop bit and the holding register updates one edge later.
    function automatic int riseEdge(input int p, input int k);
        int first;
        first = tickBase + ((p + 4 - tickBase + BD - 1) / BD) * BD;
        return first + (k - 1) * BD + 1;
    endfunction

    function automatic int frameTicks(input int n, input bit hasPar, input int nStop);
        return OS / 2 + (n + int'(hasPar) + nStop) * OS;
    endfunction

    // Drive one complete frame starting just after a rising edge and queue its expected result
    task automatic applyStimulus(input logic [7:0] d, input int n, input bit hasPar, input bit parBit,
                                 input bit odd, input int nStop, input bit s1, input bit s2);
        frame_t     f;
        logic [7:0] m;
        data_bits  = 2'(n - 5);
        parity_en  = hasPar;
        parity_odd = odd;
        stop2      = (nStop == 2);
        m          = d & ((8'd1 << n) - 8'd1);
        f.data     = m;
        f.pe       = hasPar && (((^m) ^ parBit) != odd);
        f.fe       = !s1 || (nStop == 2 && !s2);
        f.bd       = (m == 8'd0) && !(hasPar && parBit) && !s1;
        f.rise     = riseEdge(cyc, frameTicks(n, hasPar, nStop));
        expQ.push_back(f);
        RX = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < n; i++) begin
            RX = d[i];
            waitCycles(BIT_CYC);
        end
        if (hasPar) begin
            RX = parBit;
            waitCycles(BIT_CYC);
        end
        RX = s1;
        waitCycles(BIT_CYC);
        if (nStop == 2) begin
            RX = s2;
            waitCycles(BIT_CYC);
        end
        RX = 1'b1;
        waitCycles(BIT_CYC);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        checkOutput("valid_cleared", rx_valid, 0);
    endtask

    task automatic releaseReset();
        @(negedge PCLK);
        #1;
        PRESETn  = 1'b1;
        tickBase = cyc + 1;
        waitCycles(2);
    endtask

    // Frame-level model: completions land at their predicted edge; a completion while the held
    // character is neither free nor being consumed is dropped with an overrun pulse.
    always @(negedge PCLK) begin
        bit accepted;
        bit due;
        bit expOv;
        if (!PRESETn) begin
            mValid  = 0;
            prevRdy = 0;
            prevVld = 0;
            expQ.delete();
        end else begin
            accepted = prevRdy && prevVld;
            due      = (expQ.size() > 0) && (expQ[0].rise == cyc);
            expOv    = 0;
            if (due) begin
                if (!mValid || accepted) begin
                    held   = expQ[0];
                    mValid = 1;
                end else begin
                    expOv = 1;
                end
                void'(expQ.pop_front());
            end else if (accepted) begin
                mValid = 0;
            end
            if (overrun_err === 1'b1) ovSeen++;
            checkOutput("overrun_err", overrun_err, expOv);
            checkOutput("rx_valid", rx_valid, mValid);
            if (mValid) begin
                checkOutput("rx_fields", {rx_data, parity_err, frame_err, break_det},
                            {held.data, held.pe, held.fe, held.bd});
            end
            prevRdy = rx_ready;
            prevVld = rx_valid;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int r;
        #1;
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_parity_err", parity_err, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_break_det", break_det, 0);
        checkOutput("reset_overrun_err", overrun_err, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        repeat (3) @(posedge PCLK);
        releaseReset();

        $display("[TB] 8N1 0xA5");
        applyStimulus(8'hA5, 8, 0, 0, 0, 1, 1, 1);
        checkOutput("a5_data", rx_data, 8'hA5);
        checkOutput("a5_valid", rx_valid, 1);
        checkOutput("a5_flags", {parity_err, frame_err, break_det}, 3'b000);
        consume();

        $display("[TB] glitch rejection");
        RX = 1'b0;
        waitCycles(10);
        checkOutput("glitch_busy", rx_busy, 1);
        waitCycles(10);
        RX = 1'b1;
        waitCycles(60);
        checkOutput("glitch_idle", rx_busy, 0);
        checkOutput("glitch_no_valid", rx_valid, 0);

        $display("[TB] 7E1 bad parity, 7O1 good parity");
        applyStimulus(8'h35, 7, 1, 1, 0, 1, 1, 1);
        checkOutput("7e1_data", rx_data, 8'h35);
        checkOutput("7e1_parity_err", parity_err, 1);
        consume();
        applyStimulus(8'h35, 7, 1, 1, 1, 1, 1, 1);
        checkOutput("7o1_data", rx_data, 8'h35);
        checkOutput("7o1_parity_err", parity_err, 0);
        consume();

        $display("[TB] framing and break");
        applyStimulus(8'h3C, 8, 0, 0, 0, 2, 1, 0);
        checkOutput("8n2_frame_err", frame_err, 1);
        checkOutput("8n2_break_det", break_det, 0);
        consume();
        applyStimulus(8'h00, 8, 0, 0, 0, 1, 0, 1);
        checkOutput("break_data", rx_data, 8'h00);
        checkOutput("break_frame_err", frame_err, 1);
        checkOutput("break_det", break_det, 1);
        consume();

        $display("[TB] overrun");
        applyStimulus(8'h11, 8, 0, 0, 0, 1, 1, 1);
        applyStimulus(8'h22, 8, 0, 0, 0, 1, 1, 1);
        checkOutput("overrun_held_data", rx_data, 8'h11);
        checkOutput("overrun_pulses", ovSeen, 1);
        consume();

        $display("[TB] consume on completion cycle");
        applyStimulus(8'h11, 8, 0, 0, 0, 1, 1, 1);
        p = cyc;
        r = riseEdge(p, frameTicks(8, 0, 1));
        fork
            applyStimulus(8'h22, 8, 0, 0, 0, 1, 1, 1);
            begin
                while (cyc < r - 1) waitCycles(1);
                rx_ready = 1'b1;
                waitCycles(1);
                rx_ready = 1'b0;
            end
        join
        checkOutput("replace_data", rx_data, 8'h22);
        checkOutput("replace_valid", rx_valid, 1);
        checkOutput("replace_no_overrun", ovSeen, 1);

        $display("[TB] reset mid-frame");
        data_bits = 2'b11;
        parity_en = 1'b0;
        stop2     = 1'b0;
        RX = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < 3; i++) begin
            RX = (i % 2 == 1);
            waitCycles(BIT_CYC);
        end
        RX = 1'b1;
        waitCycles(BIT_CYC / 2);
        checkOutput("midframe_busy", rx_busy, 1);
        PRESETn = 1'b0;
        #1;
        checkOutput("midreset_outputs",
                    {rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy}, 0);
        RX = 1'b1;
        waitCycles(3);
        releaseReset();
        applyStimulus(8'h5A, 8, 0, 0, 0, 1, 1, 1);
        checkOutput("after_reset_data", rx_data, 8'h5A);
        checkOutput("after_reset_valid", rx_valid, 1);
        consume();

        waitCycles(4);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
